// File: rtl/ledwalk_sched.sv
// Command-driven LED walker: accepts sweep commands, steps a single lit LED 0..N-1..1
// at a programmable period, and reports completion with a one-cycle done pulse.
module ledwalk_sched #(
  parameter int unsigned NLEDS       = 8,
  parameter int unsigned STEP_CLOCKS = 6_250_000,
  parameter int unsigned SWEEP_W     = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [SWEEP_W-1:0] i_cmd_sweeps,
  input  logic [1:0]         i_cmd_rate,
  input  logic               i_abort,
  output logic [NLEDS-1:0]   o_led,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned LastIdx = 2 * NLEDS - 3;
  localparam int unsigned IdxW    = (LastIdx > 0) ? $clog2(LastIdx + 1) : 1;
  localparam int unsigned TimerW  = $clog2(STEP_CLOCKS + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [TimerW-1:0]   period_q, period_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [SWEEP_W-1:0]  sweeps_q, sweeps_d;
  logic [SWEEP_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic [NLEDS-1:0]    led_q, led_d;
  logic                done_q, done_d;

  logic                cmd_ready;
  logic [TimerW-1:0]   period_shift;
  logic [TimerW-1:0]   period_new;
  logic [SWEEP_W-1:0]  sweep_inc;
  logic [IdxW-1:0]     idx_inc;

  // Indices past the far end fold back toward LED 1 for the return leg.
  function automatic logic [NLEDS-1:0] led_map(input logic [IdxW-1:0] idx);
    int unsigned pos;
    if (32'(idx) <= NLEDS - 1) begin
      pos = 32'(idx);
    end else begin
      pos = 2 * NLEDS - 2 - 32'(idx);
    end
    return NLEDS'(1) << pos;
  endfunction

  assign cmd_ready    = (state_q == StIdle) && !i_abort && i_reset_n;
  assign o_cmd_ready  = cmd_ready;
  assign o_led        = led_q;
  assign o_busy       = (state_q == StRun);
  assign o_done       = done_q;

  always_comb begin
    period_shift = TimerW'(STEP_CLOCKS) >> i_cmd_rate;
    period_new   = (period_shift == '0) ? TimerW'(1) : period_shift;
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    period_d    = period_q;
    idx_d       = idx_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    led_d       = led_q;
    done_d      = 1'b0;
    sweep_inc   = sweep_cnt_q + SWEEP_W'(1);
    idx_inc     = idx_q + IdxW'(1);

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid && cmd_ready) begin
          state_d     = StRun;
          sweeps_d    = i_cmd_sweeps;
          period_d    = period_new;
          timer_d     = '0;
          idx_d       = '0;
          sweep_cnt_d = '0;
          led_d       = led_map('0);
        end
      end
      StRun: begin
        // Abort outranks a completion landing on the same edge.
        if (i_abort) begin
          state_d = StIdle;
          led_d   = '0;
          timer_d = '0;
          idx_d   = '0;
        end else if (timer_q == period_q - TimerW'(1)) begin
          timer_d = '0;
          if (idx_q == IdxW'(LastIdx)) begin
            idx_d       = '0;
            sweep_cnt_d = sweep_inc;
            led_d       = led_map('0);
            if ((sweeps_q != '0) && (sweep_inc == sweeps_q)) begin
              state_d = StIdle;
              led_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            idx_d = idx_inc;
            led_d = led_map(idx_inc);
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      period_q    <= TimerW'(1);
      idx_q       <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      period_q    <= period_d;
      idx_q       <= idx_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  a_run_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == StRun) |-> $onehot(led_q));
  a_idle_dark: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == StIdle) |-> (led_q == '0));
  a_timer_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (state_q == StRun) |-> (timer_q < period_q));
  a_idx_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    32'(idx_q) <= LastIdx);
  a_done_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(done_q && (state_q == StRun)));

endmodule

// File: tb/tb_ledwalk_sched.sv
// Scoreboard bench for ledwalk_sched: stimulus queues expected LED changes, done pulses and
// state snapshots; an independent monitor compares them as the DUT produces them.
module tb_ledwalk_sched;

  localparam int unsigned NLEDS = 8;
  localparam int unsigned STEP  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_sweeps;
  logic [1:0] cmd_rate;
  logic       abort;
  logic [7:0] led;
  logic       busy;
  logic       done;

  ledwalk_sched #(
    .NLEDS      (NLEDS),
    .STEP_CLOCKS(STEP),
    .SWEEP_W    (4)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_sweeps(cmd_sweeps),
    .i_cmd_rate  (cmd_rate),
    .i_abort     (abort),
    .o_led       (led),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [7:0] led;} led_ev_t;
  typedef struct {int cyc; logic [7:0] led; logic busy; logic done; logic ready;} snap_t;

  led_ev_t led_exp_q[$];
  int      done_exp_q[$];
  snap_t   snap_exp_q[$];

  int   n_chk = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic fin_req = 1'b0;
  logic fin_ack = 1'b0;

  function automatic logic [7:0] exp_led(input int j);
    int         idx;
    logic [7:0] one;
    one = 8'd1;
    idx = j % 14;
    if (idx <= 7) return one << idx;
    return one << (14 - idx);
  endfunction

  function automatic int period_of(input int r);
    int p;
    p = STEP >> r;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic push_snap(input int c, input logic [7:0] l, input logic b, input logic d,
                           input logic r);
    snap_t s;
    s.cyc = c; s.led = l; s.busy = b; s.done = d; s.ready = r;
    snap_exp_q.push_back(s);
  endtask

  task automatic push_led(input int c, input logic [7:0] l);
    led_ev_t e;
    e.cyc = c; e.led = l;
    led_exp_q.push_back(e);
  endtask

  // Expected LED trace for a run accepted at edge k; stop>0 is an abort/reset edge.
  task automatic push_run(input int k, input int s, input int r, input int stop);
    int p;
    int end_c;
    p = period_of(r);
    end_c = (s > 0) ? k + s * 14 * p : 0;
    if (stop > 0 && (s == 0 || stop <= end_c)) begin
      for (int j = 0; k + j * p < stop; j++) push_led(k + j * p, exp_led(j));
      push_led(stop, 8'h00);
    end else begin
      for (int j = 0; j < s * 14; j++) push_led(k + j * p, exp_led(j));
      push_led(end_c, 8'h00);
      done_exp_q.push_back(end_c);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) idle(1);
  endtask

  task automatic do_stop(input int stop, input int kind);
    wait_to(stop - 1);
    if (kind == 1) abort = 1'b1;
    else rst_n = 1'b0;
    idle(1);
    abort = 1'b0;
    rst_n = 1'b1;
    push_snap(stop, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic issue(input int s, input int r, input int stop_off, input int kind,
                       output int k, output int end_c);
    int stop;
    cmd_sweeps = 4'(s);
    cmd_rate   = 2'(r);
    cmd_valid  = 1'b1;
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b1);
    k = cyc + 1;
    stop = (stop_off > 0) ? k + stop_off : 0;
    push_run(k, s, r, stop);
    end_c = (stop > 0) ? stop : k + s * 14 * period_of(r);
    idle(1);
    cmd_valid = 1'b0;
    if (stop > 0) do_stop(stop, kind);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: the only process that compares.
  initial begin
    logic [7:0] prev_led;
    snap_t      s;
    led_ev_t    e;
    int         dc;
    prev_led = 8'h00;
    forever begin
      @(negedge clk);
      while (snap_exp_q.size() > 0 && snap_exp_q[0].cyc <= cyc) begin
        s = snap_exp_q.pop_front();
        check("snap_cycle", cyc, s.cyc);
        check("snap_state", {led, busy, done, cmd_ready}, {s.led, s.busy, s.done, s.ready});
      end
      if (mon_en) begin
        if (led !== prev_led) begin
          if (led_exp_q.size() == 0) begin
            check("led_unexpected", led, prev_led);
          end else begin
            e = led_exp_q.pop_front();
            check("led_value", led, e.led);
            check("led_cycle", cyc, e.cyc);
            check("led_busy", busy, (e.led != 8'h00));
          end
          prev_led = led;
        end
        if (done !== 1'b0) begin
          if (done_exp_q.size() == 0) begin
            check("done_unexpected", done, 1'b0);
          end else begin
            dc = done_exp_q.pop_front();
            check("done_cycle", cyc, dc);
          end
        end
      end
      if (fin_req && !fin_ack) begin
        check("led_events_left", led_exp_q.size(), 0);
        check("done_events_left", done_exp_q.size(), 0);
        check("snaps_left", snap_exp_q.size(), 0);
        fin_ack = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int e;
    int k2;
    rst_n      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_sweeps = 4'd1;
    cmd_rate   = 2'd0;
    abort      = 1'b0;

    // Valid held during reset must not be accepted.
    idle(3);
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    mon_en    = 1'b1;
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);

    issue(1, 0, 0, 0, k, e);
    wait_to(e);
    idle(3);

    issue(2, 2, 0, 0, k, e);
    wait_to(e);
    idle(2);

    issue(2, 3, 0, 0, k, e);
    wait_to(e);
    idle(2);

    // Abort in idle blocks a simultaneous valid.
    cmd_valid = 1'b1;
    abort     = 1'b1;
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    push_snap(cyc, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(2);

    issue(0, 0, 200, 1, k, e);
    idle(3);

    // Abort lands on the final step edge: no done pulse.
    issue(1, 0, 56, 1, k, e);
    idle(3);

    // Valid held through completion is accepted the cycle after done, then reset mid-run.
    issue(1, 2, 0, 0, k, e);
    cmd_sweeps = 4'd3;
    cmd_rate   = 2'd1;
    cmd_valid  = 1'b1;
    k2 = e + 1;
    push_snap(e, 8'h00, 1'b0, 1'b1, 1'b1);
    push_run(k2, 3, 1, k2 + 30);
    wait_to(k2);
    cmd_valid = 1'b0;
    do_stop(k2 + 30, 2);
    idle(3);

    fin_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ledwalk_sched.md
Name: ledwalk_sched

Overview:
Command-driven sequencer for the 8-LED walker display. It accepts sweep commands over a valid/ready handshake, times each LED step from a programmable period, and walks a single lit LED 0→7→0 for a requested number of sweeps (or forever). It sits between board-level control (buttons, UART command decoder) and the LED pins, and owns o_led exclusively.

Parameters:
NLEDS, 8, number of LEDs; must be at least 2; the walk spans indices 0..2*NLEDS-3.
STEP_CLOCKS, 6_250_000, base step period in clocks at rate 0; must be at least 1.
SWEEP_W, 4, width of the sweep-count field.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  synchronous active-low reset
i_cmd_valid  input  1  command request
o_cmd_ready  output  1  command accept (combinational)
i_cmd_sweeps  input  SWEEP_W  sweeps to run; 0 = run until abort
i_cmd_rate  input  2  speed select; period = max(STEP_CLOCKS >> rate, 1)
i_abort  input  1  stop current run
o_led  output  NLEDS  one-hot LED drive, or all-zero when idle
o_busy  output  1  high while in RUN
o_done  output  1  one-cycle pulse on normal completion

Behaviour:
- One clock (i_clk). Reset is synchronous and active-low (i_reset_n).
- Reset (i_reset_n=0 at posedge), including mid-run, forces:
  - state IDLE, o_led=0, o_busy=0, o_done=0
  - step timer=0, index=0, sweep counter=0
- States:
  - IDLE: o_busy=0, o_led=0.
  - RUN: o_busy=1, o_led one-hot.
- o_cmd_ready = (state==IDLE) && !i_abort && i_reset_n. Commands presented during RUN are held off (ready=0) and are not queued.
- Accept (valid && ready at posedge k):
  - Latch sweeps and period = max(STEP_CLOCKS >> i_cmd_rate, 1).
  - Set index=0, timer=0, sweep counter=0, state RUN.
  - o_led=1 after edge k.
- Step timer:
  - Width $clog2(STEP_CLOCKS+1).
  - Counts 0..period-1. At period-1 it wraps to 0 and the index advances, so each LED position is held exactly period cycles.
- Index and LED mapping:
  - Index runs 0..2*NLEDS-3.
  - o_led = 1<<index for index ≤ NLEDS-1.
  - o_led = 1<<(2*NLEDS-2-index) above that.
  - o_led is registered and updates on the same edge as the index.
- End of sweep (step at index 2*NLEDS-3):
  - Index wraps to 0 and the sweep counter increments (SWEEP_W bits).
  - If latched sweeps≠0 and the incremented count==sweeps, complete: state IDLE, o_led=0, o_busy=0, o_done=1 for exactly one cycle. o_cmd_ready is high in that same cycle, so back-to-back commands are allowed.
  - If latched sweeps==0, the sweep counter free-runs (wrap ignored) and the run never completes on its own.
- Abort:
  - i_abort=1 in RUN at a posedge: next state IDLE, o_led=0, o_busy=0, no o_done pulse.
  - Abort has priority over a completion occurring on the same edge: o_done stays 0.
  - Abort in IDLE has no effect except forcing o_cmd_ready=0, so a simultaneous valid is not accepted.
- Total run time for N sweeps: N*(2*NLEDS-2)*period cycles from accept edge to the done edge.
- Invariants:
  - o_led is one-hot in RUN and zero in IDLE.
  - o_busy == (o_led≠0).
  - timer < period.
  - index ≤ 2*NLEDS-3.
  - o_done never high while o_busy.

Test Plan:
- Reset then idle, with STEP_CLOCKS=4, NLEDS=8 → o_led=00, o_busy=0, o_done=0, o_cmd_ready=1; valid raised during reset is not accepted.
- Accept sweeps=1, rate=0 → o_led steps 01,02,04,…,80,40,…,02, each held 4 cycles; o_done pulses 56 cycles after the accept edge; o_led=00 thereafter.
- Accept sweeps=2, rate=2 (period 1) → LED changes every cycle; done at 28 cycles. Then rate=3 (4>>3=0, clamped to 1) → also done at 28 cycles for 2 sweeps.
- sweeps=0, rate=0, run 200 cycles → never done and never idle; abort at cycle 200 → o_led=00 and o_busy=0 next cycle, no o_done.
- Pulse i_abort on the same edge as the final step of a sweeps=1 run → o_done remains 0; idle with o_led=00.
- New valid held high through completion → accepted on the done cycle; o_led=01 on the next cycle. Assert i_reset_n=0 mid-run → everything cleared on the following edge.
